// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives a single-outstanding imem port,
// and holds the IF/ID register with a 1-entry skid buffer for ID stalls.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_id,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        ifid_flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_id,
  output logic [31:0] pc4_id,
  output logic        valid_id
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] fpc, fpc_n;
  logic [31:0] skid_instr, skid_pc4;
  logic        skid_load;
  logic        ld_v;
  logic [31:0] ld_instr, ld_pc4;
  logic        can_accept;
  logic [31:0] redir_pc;
  logic [31:0] fpc4;

  assign can_accept = !(stall_id && valid_id);
  assign redir_pc   = {redirect_pc[31:2], 2'b00};
  assign fpc4       = fpc + 32'd4;
  assign imem_req   = rst_n && (state == S_REQ);
  assign imem_addr  = pc;

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    fpc_n     = fpc;
    skid_load = 1'b0;
    ld_v      = 1'b0;
    ld_instr  = imem_rdata;
    ld_pc4    = fpc4;
    unique case (state)
      S_REQ: begin
        if (redirect_valid) begin
          pc_n    = redir_pc;
          state_n = imem_gnt ? S_DROP : S_REQ;
        end else if (imem_gnt) begin
          fpc_n   = pc;
          pc_n    = pc + 32'd4;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_n    = redir_pc;
          state_n = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          if (can_accept) begin
            ld_v    = 1'b1;
            state_n = S_REQ;
          end else begin
            skid_load = 1'b1;
            state_n   = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_n    = redir_pc;
          state_n = S_REQ;
        end else if (can_accept) begin
          ld_v     = 1'b1;
          ld_instr = skid_instr;
          ld_pc4   = skid_pc4;
          state_n  = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect_valid) pc_n = redir_pc;
        if (imem_rvalid) state_n = S_REQ;
      end
      default: state_n = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      fpc        <= 32'h0;
      skid_instr <= NOP_INSTR;
      skid_pc4   <= 32'h0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      fpc   <= fpc_n;
      if (skid_load) begin
        skid_instr <= imem_rdata;
        skid_pc4   <= fpc4;
      end
    end
  end

  // Flush beats stall; stall beats load; no load means a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_id <= 1'b0;
      instr_id <= NOP_INSTR;
      pc4_id   <= 32'h0;
    end else if (ifid_flush) begin
      valid_id <= 1'b0;
      instr_id <= NOP_INSTR;
    end else if (stall_id && valid_id) begin
      valid_id <= valid_id;
    end else if (ld_v) begin
      valid_id <= 1'b1;
      instr_id <= ld_instr;
      pc4_id   <= ld_pc4;
    end else begin
      valid_id <= 1'b0;
      instr_id <= NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: reset, streaming, stall/skid,
// redirects, flush collision and PC wrap.
module tb_if_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_id;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ifid_flush;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  logic        req;
  logic [31:0] addr;
  logic [31:0] instr;
  logic [31:0] pc4;
  logic        valid;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_instr;
  logic [31:0] w_pc4;
  logic        w_valid;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_id(stall_id),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ifid_flush(ifid_flush), .imem_req(req), .imem_addr(addr),
    .imem_gnt(gnt), .imem_rvalid(rvalid), .imem_rdata(rdata),
    .instr_id(instr), .pc4_id(pc4), .valid_id(valid)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .stall_id(stall_id),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ifid_flush(ifid_flush), .imem_req(w_req), .imem_addr(w_addr),
    .imem_gnt(gnt), .imem_rvalid(rvalid), .imem_rdata(rdata),
    .instr_id(w_instr), .pc4_id(w_pc4), .valid_id(w_valid)
  );

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cyc(); cyc(); cyc();
    total++;
    if (req !== 1'b0) begin
      bad++; $display("FAIL rst_req act=%0h exp=0", req);
    end
    total++;
    if (valid !== 1'b0) begin
      bad++; $display("FAIL rst_valid act=%0h exp=0", valid);
    end
    total++;
    if (instr !== 32'h0) begin
      bad++; $display("FAIL rst_instr act=%0h exp=0", instr);
    end
    total++;
    if (pc4 !== 32'h0) begin
      bad++; $display("FAIL rst_pc4 act=%0h exp=0", pc4);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (req !== 1'b1 || addr !== 32'h0) begin
      bad++; $display("FAIL rel_req act=%0h/%0h exp=1/0", req, addr);
    end
  endtask

  task automatic test_streaming;
    gnt = 1'b1;
    cyc();
    total++;
    if (req !== 1'b0) begin
      bad++; $display("FAIL st_wait_req act=%0h exp=0", req);
    end
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h2008_0005;
    cyc();
    total++;
    if (valid !== 1'b1 || pc4 !== 32'h4 || instr !== 32'h2008_0005) begin
      bad++; $display("FAIL st_i0 act=%0h/%0h/%0h exp=1/4/20080005", valid, pc4, instr);
    end
    total++;
    if (req !== 1'b1 || addr !== 32'h4) begin
      bad++; $display("FAIL st_addr4 act=%0h/%0h exp=1/4", req, addr);
    end
    rvalid = 1'b0; gnt = 1'b1;
    cyc();
    total++;
    if (valid !== 1'b0 || req !== 1'b0) begin
      bad++; $display("FAIL st_bubble act=%0h/%0h exp=0/0", valid, req);
    end
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h2009_0007;
    cyc();
    total++;
    if (valid !== 1'b1 || pc4 !== 32'h8 || instr !== 32'h2009_0007) begin
      bad++; $display("FAIL st_i1 act=%0h/%0h/%0h exp=1/8/20090007", valid, pc4, instr);
    end
    total++;
    if (req !== 1'b1 || addr !== 32'h8) begin
      bad++; $display("FAIL st_addr8 act=%0h/%0h exp=1/8", req, addr);
    end
    rvalid = 1'b0;
  endtask

  task automatic test_stall;
    stall_id = 1'b1; gnt = 1'b1;
    cyc();
    total++;
    if (valid !== 1'b1 || pc4 !== 32'h8 || instr !== 32'h2009_0007) begin
      bad++; $display("FAIL sl_hold1 act=%0h/%0h/%0h exp=1/8/20090007", valid, pc4, instr);
    end
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h200A_0009;
    cyc();
    total++;
    if (req !== 1'b0 || valid !== 1'b1 || pc4 !== 32'h8) begin
      bad++; $display("FAIL sl_hold2 act=%0h/%0h/%0h exp=0/1/8", req, valid, pc4);
    end
    rvalid = 1'b0;
    cyc();
    total++;
    if (req !== 1'b0 || instr !== 32'h2009_0007 || pc4 !== 32'h8) begin
      bad++; $display("FAIL sl_hold3 act=%0h/%0h/%0h exp=0/20090007/8", req, instr, pc4);
    end
    stall_id = 1'b0;
    cyc();
    total++;
    if (valid !== 1'b1 || pc4 !== 32'hC || instr !== 32'h200A_0009) begin
      bad++; $display("FAIL sl_skid act=%0h/%0h/%0h exp=1/c/200a0009", valid, pc4, instr);
    end
    total++;
    if (req !== 1'b1 || addr !== 32'hC) begin
      bad++; $display("FAIL sl_addr act=%0h/%0h exp=1/c", req, addr);
    end
    cyc();
    total++;
    if (valid !== 1'b0) begin
      bad++; $display("FAIL sl_nodup act=%0h exp=0", valid);
    end
  endtask

  task automatic test_redirect_wait;
    gnt = 1'b1;
    cyc();
    gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    cyc();
    redirect_valid = 1'b0;
    total++;
    if (req !== 1'b0 || valid !== 1'b0) begin
      bad++; $display("FAIL rw_drop act=%0h/%0h exp=0/0", req, valid);
    end
    cyc();
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    cyc();
    rvalid = 1'b0;
    total++;
    if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'h100) begin
      bad++; $display("FAIL rw_tgt act=%0h/%0h/%0h exp=0/1/100", valid, req, addr);
    end
    gnt = 1'b1;
    cyc();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h2008_0001;
    cyc();
    rvalid = 1'b0;
    total++;
    if (valid !== 1'b1 || pc4 !== 32'h104 || instr !== 32'h2008_0001) begin
      bad++; $display("FAIL rw_new act=%0h/%0h/%0h exp=1/104/20080001", valid, pc4, instr);
    end
  endtask

  task automatic test_collision;
    stall_id = 1'b1; gnt = 1'b1;
    cyc();
    gnt = 1'b0; ifid_flush = 1'b1; redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200; rvalid = 1'b1; rdata = 32'h1234_5678;
    cyc();
    ifid_flush = 1'b0; redirect_valid = 1'b0; rvalid = 1'b0; stall_id = 1'b0;
    total++;
    if (valid !== 1'b0 || instr !== 32'h0) begin
      bad++; $display("FAIL co_flush act=%0h/%0h exp=0/0", valid, instr);
    end
    total++;
    if (req !== 1'b1 || addr !== 32'h200) begin
      bad++; $display("FAIL co_addr act=%0h/%0h exp=1/200", req, addr);
    end
    cyc();
    total++;
    if (valid !== 1'b0) begin
      bad++; $display("FAIL co_dropped act=%0h exp=0", valid);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300; gnt = 1'b1;
    cyc();
    redirect_valid = 1'b0; gnt = 1'b0;
    total++;
    if (req !== 1'b0) begin
      bad++; $display("FAIL co_reqdrop act=%0h exp=0", req);
    end
    rvalid = 1'b1; rdata = 32'h0000_0BAD;
    cyc();
    rvalid = 1'b0;
    total++;
    if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'h300) begin
      bad++; $display("FAIL co_reqtgt act=%0h/%0h/%0h exp=0/1/300", valid, req, addr);
    end
  endtask

  task automatic test_wrap;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    total++;
    if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL wr_start act=%0h/%0h exp=1/fffffffc", w_req, w_addr);
    end
    gnt = 1'b1;
    cyc();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h2008_0005;
    cyc();
    rvalid = 1'b0;
    total++;
    if (w_valid !== 1'b1 || w_pc4 !== 32'h0 || w_instr !== 32'h2008_0005) begin
      bad++; $display("FAIL wr_pc4 act=%0h/%0h/%0h exp=1/0/20080005", w_valid, w_pc4, w_instr);
    end
    total++;
    if (w_req !== 1'b1 || w_addr !== 32'h0) begin
      bad++; $display("FAIL wr_addr act=%0h/%0h exp=1/0", w_req, w_addr);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall_id = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; ifid_flush = 1'b0;
    gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    test_reset();
    test_streaming();
    test_stall();
    test_redirect_wait();
    test_collision();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
